// File: rtl/gpr_mp.sv
// Multi-port general purpose register file: NUM_CM same-cycle commit ports, NUM_RD
// combinational read ports with optional commit bypass, debug access port and dirty map.
module gpr_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 4,
  parameter int NUM_CM   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CM-1:0]        cm_en_i,
  input  logic [NUM_CM*ADDR_W-1:0] cm_addr_i,
  input  logic [NUM_CM*DATA_W-1:0] cm_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     dbg_req_i,
  input  logic                     dbg_we_i,
  input  logic [ADDR_W-1:0]        dbg_addr_i,
  input  logic [DATA_W-1:0]        dbg_wdata_i,
  output logic                     dbg_ack_o,
  output logic [DATA_W-1:0]        dbg_rdata_o,
  output logic [2**ADDR_W-1:0]     dirty_o,
  input  logic                     dirty_clr_i
);

  localparam int NUM_REGS = 2**ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } dbg_state_e;

  dbg_state_e          state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                dbg_ack_q;
  logic                dbg_accept_s;
  logic                dbg_wen_s;
  logic [NUM_CM-1:0]   cm_wen_s;
  logic [DATA_W-1:0]   rd_val_s [NUM_RD];

  // Commit ports that really write: address 0 is discarded when it is hardwired
  always_comb begin
    for (int k = 0; k < NUM_CM; k++) begin
      cm_wen_s[k] = cm_en_i[k] &&
                    !((ZERO_REG != 0) && (cm_addr_i[k*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}}));
    end
    dbg_wen_s = dbg_accept_s && dbg_we_i &&
                !((ZERO_REG != 0) && (dbg_addr_i == {ADDR_W{1'b0}}));
  end

  // Debug FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Debug FSM next state: commits take priority, so a request waits while any cm_en is set
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dbg_req_i && (cm_en_i == {NUM_CM{1'b0}})) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Debug FSM outputs: accept strobe is only raised in IDLE
  always_comb begin
    dbg_accept_s = 1'b0;
    case (state_q)
      ST_IDLE: dbg_accept_s = dbg_req_i && (cm_en_i == {NUM_CM{1'b0}});
      ST_ACK:  dbg_accept_s = 1'b0;
      default: dbg_accept_s = 1'b0;
    endcase
  end

  // Array and dirty next state; later commit ports overwrite earlier ones
  always_comb begin
    if (dirty_clr_i) begin
      dirty_d = {NUM_REGS{1'b0}};
    end else begin
      dirty_d = dirty_q;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      for (int k = 0; k < NUM_CM; k++) begin
        if (cm_wen_s[k] && (cm_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
          regs_d[i]  = cm_data_i[k*DATA_W +: DATA_W];
          dirty_d[i] = 1'b1;
        end else begin
          regs_d[i]  = regs_d[i];
        end
      end
      if (dbg_wen_s && (dbg_addr_i == ADDR_W'(i))) begin
        regs_d[i]  = dbg_wdata_i;
        dirty_d[i] = 1'b1;
      end else begin
        regs_d[i]  = regs_d[i];
      end
    end
  end

  // Debug read capture; never bypassed, and held until the next debug read
  always_comb begin
    if (dbg_accept_s && !dbg_we_i) begin
      dbg_rdata_d = regs_q[dbg_addr_i];
    end else begin
      dbg_rdata_d = dbg_rdata_q;
    end
  end

  // Register array, dirty map and debug response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      dirty_q     <= {NUM_REGS{1'b0}};
      dbg_rdata_q <= {DATA_W{1'b0}};
      dbg_ack_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      dirty_q     <= dirty_d;
      dbg_rdata_q <= dbg_rdata_d;
      dbg_ack_q   <= dbg_accept_s;
    end
  end

  // Read ports: array value, overridden by the youngest matching commit, zero reg last
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      rd_val_s[j] = regs_q[rd_addr_i[j*ADDR_W +: ADDR_W]];
      for (int k = 0; k < NUM_CM; k++) begin
        if ((BYPASS != 0) && cm_en_i[k] &&
            (cm_addr_i[k*ADDR_W +: ADDR_W] == rd_addr_i[j*ADDR_W +: ADDR_W])) begin
          rd_val_s[j] = cm_data_i[k*DATA_W +: DATA_W];
        end else begin
          rd_val_s[j] = rd_val_s[j];
        end
      end
      if ((ZERO_REG != 0) && (rd_addr_i[j*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}})) begin
        rd_val_s[j] = {DATA_W{1'b0}};
      end else begin
        rd_val_s[j] = rd_val_s[j];
      end
    end
  end

  // Pack read results onto the output bus
  always_comb begin
    rd_data_o = {(NUM_RD*DATA_W){1'b0}};
    for (int j = 0; j < NUM_RD; j++) begin
      rd_data_o[j*DATA_W +: DATA_W] = rd_val_s[j];
    end
  end

  assign dbg_ack_o   = dbg_ack_q;
  assign dbg_rdata_o = dbg_rdata_q;
  assign dirty_o     = dirty_q;

endmodule
